// File: rtl/seg7_scan_if.sv
// Bundle of the display driver's data-side strobes and the display pin outputs.
// The producer of digit data uses master; the scan driver uses slave.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [1:0]                code_mode;
    logic [4*NUM_DIGITS-1:0]   data_in;
    logic [NUM_DIGITS-1:0]     blink_mask;
    logic                      lz_suppress;
    logic [6:0]                seg_out;
    logic [NUM_DIGITS-1:0]     an_out;
    logic                      code_err;

    modport master (
        output load, code_mode, data_in, blink_mask, lz_suppress,
        input  seg_out, an_out, code_err
    );

    modport slave (
        input  load, code_mode, data_in, blink_mask, lz_suppress,
        output seg_out, an_out, code_err
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver: shadow register, BCD/excess-3/hex
// decode, leading-zero suppression, per-digit blink and a blank cycle at each slot start.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 4,
    parameter int BLINK_DIV  = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    seg7_scan_if.slave  io_bus
);

    localparam int PRE_W = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;

    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0]      FRM_LAST = FRM_W'(BLINK_DIV - 1);
    localparam logic [6:0]            SEG_OFF  = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        MODE_BCD = 2'd0,
        MODE_EX3 = 2'd1,
        MODE_HEX = 2'd2,
        MODE_OFF = 2'd3
    } mode_t;

    // Returns {valid, value} for one 4-bit code under the given mode.
    function automatic logic [4:0] decodeDigit(input logic [3:0] code, input mode_t mode);
        logic       valid;
        logic [3:0] value;
        valid = 1'b0;
        value = 4'd0;
        case (mode)
            MODE_BCD: begin
                valid = (code <= 4'd9);
                value = code;
            end
            MODE_EX3: begin
                valid = (code >= 4'd3) && (code <= 4'd12);
                value = code - 4'd3;
            end
            MODE_HEX: begin
                valid = 1'b1;
                value = code;
            end
            default: begin
                valid = 1'b0;
                value = 4'd0;
            end
        endcase
        return {valid, value};
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'b1111110;
            4'h1:    seg = 7'b0110000;
            4'h2:    seg = 7'b1101101;
            4'h3:    seg = 7'b1111001;
            4'h4:    seg = 7'b0110011;
            4'h5:    seg = 7'b1011011;
            4'h6:    seg = 7'b1011111;
            4'h7:    seg = 7'b1110000;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1111011;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b0011111;
            4'hC:    seg = 7'b1001110;
            4'hD:    seg = 7'b0111101;
            4'hE:    seg = 7'b1001111;
            default: seg = 7'b1000111;
        endcase
        return seg;
    endfunction

    logic [PRE_W-1:0]        r_pre;
    logic [IDX_W-1:0]        r_idx;
    logic [FRM_W-1:0]        r_frame;
    logic                    r_phase;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    mode_t                   r_mode;
    logic                    r_codeErr;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;

    logic [NUM_DIGITS-1:0]   w_valid;
    logic [3:0]              w_value [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_lzBlank;
    logic                    w_leading;
    logic [6:0]              w_segHigh;
    logic [NUM_DIGITS-1:0]   w_anHigh;
    logic [6:0]              w_segNext;
    logic [NUM_DIGITS-1:0]   w_anNext;

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            {w_valid[i], w_value[i]} = decodeDigit(r_shadow[4*i +: 4], r_mode);
        end
    end

    // Blank valid zeros from the top digit down until a non-zero or invalid digit; digit 0 always shows.
    always_comb begin
        w_lzBlank = '0;
        w_leading = io_bus.lz_suppress;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (w_leading && w_valid[i] && (w_value[i] == 4'd0)) begin
                w_lzBlank[i] = 1'b1;
            end else begin
                w_leading = 1'b0;
            end
        end
    end

    always_comb begin
        w_segHigh = 7'h00;
        w_anHigh  = '0;
        if ((r_pre != '0) && !(r_phase && io_bus.blink_mask[r_idx])) begin
            w_anHigh[r_idx] = 1'b1;
            if (w_valid[r_idx] && !w_lzBlank[r_idx]) begin
                w_segHigh = glyph(w_value[r_idx]);
            end
        end
        w_segNext = w_segHigh ^ SEG_OFF;
        w_anNext  = w_anHigh ^ AN_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_mode    <= MODE_BCD;
            r_codeErr <= 1'b0;
            r_seg     <= SEG_OFF;
            r_an      <= AN_OFF;
        end else begin
            if (io_bus.load) begin
                r_shadow <= io_bus.data_in;
                r_mode   <= mode_t'(io_bus.code_mode);
            end
            r_codeErr <= ~&w_valid;
            r_seg     <= w_segNext;
            r_an      <= w_anNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_idx   <= '0;
            r_frame <= '0;
            r_phase <= 1'b0;
        end else if (r_pre == PRE_LAST) begin
            r_pre <= '0;
            if (r_idx == IDX_LAST) begin
                r_idx <= '0;
                if (r_frame == FRM_LAST) begin
                    r_frame <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_frame <= r_frame + FRM_W'(1);
                end
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    assign io_bus.seg_out  = r_seg;
    assign io_bus.an_out   = r_an;
    assign io_bus.code_err = r_codeErr;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: a table of load vectors scored cycle by
// cycle through an expectation queue, plus blink and mid-slot reset sequences.
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int BD    = 2;
    localparam int FRAME = ND * SD;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seg7_scan_if #(.NUM_DIGITS(ND)) dispIf ();

    seg7_scan_driver #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .BLINK_DIV  (BD),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (dispIf)
    );

    typedef struct {
        string            name;
        logic [1:0]       mode;
        logic [15:0]      data;
        logic             lzs;
        logic [3:0][6:0]  glyphs;
        logic             err;
    } vector_t;

    typedef struct {
        string        name;
        int unsigned  tgt;
        logic [6:0]   seg;
        logic [3:0]   an;
        logic         err;
    } exp_t;

    exp_t        sbq[$];
    vector_t     vecs[11];
    int          checks = 0;
    int          passes = 0;
    int unsigned cyc = 0;
    int unsigned scanCount = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) scanCount <= 0;
        else        scanCount <= scanCount + 1;
    end

    task automatic checkOutput(input exp_t e);
        checks++;
        if (e.tgt == cyc && dispIf.seg_out === e.seg && dispIf.an_out === e.an
            && dispIf.code_err === e.err) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s cyc=%0d/%0d: seg=%b an=%b err=%b, want seg=%b an=%b err=%b",
                     e.name, cyc, e.tgt, dispIf.seg_out, dispIf.an_out, dispIf.code_err,
                     e.seg, e.an, e.err);
        end
    endtask

    // Scoreboard side: compare every expectation whose target edge has passed.
    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].tgt <= cyc) begin
            e = sbq.pop_front();
            checkOutput(e);
        end
    end

    function automatic exp_t expectFor(input int unsigned n, input logic [3:0][6:0] glyphs,
                                       input logic err, input logic [3:0] blinkMask,
                                       input string name);
        exp_t        e;
        int          pre;
        int          idx;
        int          phase;
        logic [3:0]  one;
        pre    = int'(n % SD);
        idx    = int'((n / SD) % ND);
        phase  = int'(((n / FRAME) / BD) % 2);
        one    = 4'b0001;
        e.name = name;
        e.tgt  = cyc + 1;
        e.err  = err;
        e.seg  = 7'h7F;
        e.an   = 4'hF;
        if (pre != 0 && !(phase == 1 && blinkMask[idx])) begin
            e.an  = ~(one << idx);
            e.seg = ~glyphs[idx];
        end
        return e;
    endfunction

    function automatic vector_t mkVec(input string name, input logic [1:0] mode,
                                      input logic [15:0] data, input logic lzs,
                                      input logic [3:0][6:0] glyphs, input logic err);
        vector_t v;
        v.name = name; v.mode = mode; v.data = data; v.lzs = lzs;
        v.glyphs = glyphs; v.err = err;
        return v;
    endfunction

    // Called just after a rising edge; leaves the caller just after a rising edge.
    task automatic applyStimulus(input logic [1:0] mode, input logic [15:0] data,
                                 input logic lzs, input logic [3:0] bm);
        dispIf.code_mode   = mode;
        dispIf.data_in     = data;
        dispIf.lz_suppress = lzs;
        dispIf.blink_mask  = bm;
        dispIf.load        = 1'b1;
        @(posedge clk); #1;
        dispIf.load = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic scoreCycles(input int k, input logic [3:0][6:0] glyphs, input logic err,
                               input logic [3:0] bm, input string name);
        repeat (k) begin
            sbq.push_back(expectFor(scanCount, glyphs, err, bm, name));
            @(posedge clk); #1;
        end
    endtask

    task automatic directCheck(input string name, input logic [6:0] seg, input logic [3:0] an,
                               input logic err);
        checks++;
        if (dispIf.seg_out === seg && dispIf.an_out === an && dispIf.code_err === err) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: seg=%b an=%b err=%b, want seg=%b an=%b err=%b", name,
                     dispIf.seg_out, dispIf.an_out, dispIf.code_err, seg, an, err);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = mkVec("bcd_4321",   2'd0, 16'h4321, 1'b0, {7'h33, 7'h79, 7'h6D, 7'h30}, 1'b0);
        vecs[1]  = mkVec("ex3_3C5F",   2'd1, 16'h3C5F, 1'b0, {7'h7E, 7'h7B, 7'h6D, 7'h00}, 1'b1);
        vecs[2]  = mkVec("lz_0070",    2'd0, 16'h0070, 1'b1, {7'h00, 7'h00, 7'h70, 7'h7E}, 1'b0);
        vecs[3]  = mkVec("lz_0000",    2'd0, 16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h7E}, 1'b0);
        vecs[4]  = mkVec("hex_ABCD",   2'd2, 16'hABCD, 1'b0, {7'h77, 7'h1F, 7'h4E, 7'h3D}, 1'b0);
        vecs[5]  = mkVec("mode3",      2'd3, 16'hABCD, 1'b0, {7'h00, 7'h00, 7'h00, 7'h00}, 1'b1);
        vecs[6]  = mkVec("lz_bcd9A05", 2'd0, 16'h9A05, 1'b1, {7'h7B, 7'h00, 7'h7E, 7'h5B}, 1'b1);
        vecs[7]  = mkVec("lz_ex3304",  2'd1, 16'h3304, 1'b1, {7'h00, 7'h00, 7'h00, 7'h30}, 1'b1);
        vecs[8]  = mkVec("lz_hex0E08", 2'd2, 16'h0E08, 1'b1, {7'h00, 7'h4F, 7'h7E, 7'h7F}, 1'b0);
        vecs[9]  = mkVec("nolz_0000",  2'd0, 16'h0000, 1'b0, {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 1'b0);
        vecs[10] = mkVec("lz_ex3C3A6", 2'd1, 16'hC3A6, 1'b1, {7'h7B, 7'h7E, 7'h70, 7'h79}, 1'b0);

        rst_n              = 1'b0;
        dispIf.load        = 1'b0;
        dispIf.code_mode   = 2'd0;
        dispIf.data_in     = '0;
        dispIf.blink_mask  = '0;
        dispIf.lz_suppress = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        directCheck("reset_state", 7'h7F, 4'hF, 1'b0);

        rst_n = 1'b1;
        scoreCycles(2 * FRAME, {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 1'b0, 4'b0000, "post_release");

        for (int v = 0; v < 11; v++) begin
            applyStimulus(vecs[v].mode, vecs[v].data, vecs[v].lzs, 4'b0000);
            scoreCycles(FRAME, vecs[v].glyphs, vecs[v].err, 4'b0000, vecs[v].name);
        end

        $display("[TB] blink sequence, mask 0001");
        applyStimulus(2'd0, 16'h4321, 1'b0, 4'b0001);
        scoreCycles(4 * FRAME, vecs[0].glyphs, 1'b0, 4'b0001, "blink");
        dispIf.blink_mask = 4'b0000;

        $display("[TB] mid-slot reset on digit 2");
        for (int k = 0; k < 2 * FRAME && (scanCount % FRAME) != 10; k++) begin
            @(posedge clk); #1;
        end
        directCheck("pre_reset_digit2", ~7'h79, 4'b1011, 1'b0);
        rst_n = 1'b0;
        #1;
        directCheck("async_reset", 7'h7F, 4'hF, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        scoreCycles(FRAME, {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 1'b0, 4'b0000, "restart");

        repeat (3) @(posedge clk);
        #1;
        if (sbq.size() != 0) begin
            checks++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", sbq.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multi-digit, time-multiplexed 7-segment display driver. It generalises the single-digit excess-3 decoder to NUM_DIGITS digits sharing one segment bus. Each digit is decoded in selectable BCD, excess-3 or hex mode, with leading-zero suppression, per-digit blink and anti-ghosting blanking. It sits between the arithmetic/result registers and the board's common-anode display pins.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1..8)
- SCAN_DIV, 4, clock cycles per digit slot (>= 2)
- BLINK_DIV, 8, complete scan frames per blink half-period (>= 1)
- ACTIVE_LOW, 1, 1 = segment and anode outputs are active-low; 0 = active-high
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- load  input  1  capture strobe for data_in/code_mode
- code_mode  input  2  0 = BCD, 1 = excess-3, 2 = hex, 3 = reserved (all digits blank)
- data_in  input  4*NUM_DIGITS  packed digit codes; digit 0 = bits [3:0], the least significant digit
- blink_mask  input  NUM_DIGITS  per-digit blink enable, sampled live
- lz_suppress  input  1  leading-zero suppression enable, sampled live
- seg_out  output  7  segments {a,b,c,d,e,f,g}, a = bit 6, polarity per ACTIVE_LOW
- an_out  output  NUM_DIGITS  one-hot digit select, bit i = digit i, polarity per ACTIVE_LOW
- code_err  output  1  high while any captured digit is invalid for the captured mode

## Operation
- Shadow register: when load = 1 at a rising edge, data_in and code_mode are captured. Between loads the display is driven only from the shadow register.
- Decode value v per digit:
  - BCD: v = code, valid for 0..9.
  - Excess-3: v = code − 3, valid for codes 3..12.
  - Hex: v = code, always valid.
  - Mode 3: every digit is invalid.
- Glyphs, active-high abcdefg:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - A = 1110111, b = 0011111, C = 1001110, d = 0111101, E = 1001111, F = 1000111
- An invalid digit is blank (all segments off). ACTIVE_LOW = 1 inverts both the segment and anode buses.
- Leading-zero suppression (lz_suppress = 1):
  - Starting from digit NUM_DIGITS−1 downward, each digit with valid v = 0 is blanked until the first digit that is non-zero or invalid.
  - Digit 0 is never suppressed.
- Scan:
  - Prescaler pre counts 0..SCAN_DIV−1.
  - When pre = SCAN_DIV−1, the digit index idx advances, wrapping from NUM_DIGITS−1 to 0.
  - A wrap of idx completes one frame.
- Blink:
  - The frame counter counts 0..BLINK_DIV−1.
  - At its terminal count on a frame completion, blink phase toggles.
  - While phase = 1, every digit with its blink_mask bit set is blanked: anode inactive, segments off.
- code_err is registered from the shadow contents and updates on the cycle after a load.

## Timing
- Reset (async assert, immediate): pre = 0, idx = 0, shadow = 0, mode = BCD, frame = 0, phase = 0, code_err = 0. All segments and all anodes go to their inactive level (seg_out = 7'h7F and an_out all ones when ACTIVE_LOW = 1).
- Reset release: scanning starts at digit 0 on the first clock edge.
- Reset asserted mid-frame or mid-slot: outputs go inactive immediately; the scan restarts from digit 0 on release.
- seg_out and an_out are registered and reflect pre/idx/shadow of the previous cycle (1-cycle latency).
- Slot anti-ghosting: in the output cycle corresponding to pre = 0, all anodes are inactive and segments are off. Digit idx is driven for the remaining SCAN_DIV−1 cycles of its slot.
- Full frame = NUM_DIGITS*SCAN_DIV cycles. Blink half-period = BLINK_DIV frames.
- load during a slot: the new value appears on seg_out 2 cycles after the load edge (1 cycle to capture, 1 cycle of output register), even mid-slot. load held high recaptures every cycle.
- Changes to lz_suppress and blink_mask take effect on the next output-register update (1 cycle).
- NUM_DIGITS = 1: idx stays 0; every slot still begins with the 1-cycle blank.

## Test plan
- Defaults, ACTIVE_LOW = 1. Reset, release, load data_in = 16'h4321 in BCD → an_out cycles 1110 → 1101 → 1011 → 0111, each digit 3 cycles preceded by 1 all-off cycle; seg_out = ~1111001, ~1101101, ~0110000, ~0110011 for digits 0, 1, 2, 3 (values 1, 2, 3, 4).
- Excess-3, data_in = 16'h3C5F → digit 0 (code F) blank and code_err = 1 one cycle after load. Digits 1, 2, 3 show 2, 9, 0.
- lz_suppress = 1, BCD 16'h0070 → digits 3 and 2 blank; digit 1 shows 7 (1110000); digit 0 shows 0 (1111110).
- Leading-zero boundary, same setup with 16'h0000 → only digit 0 is lit, showing 0.
- BLINK_DIV = 2, blink_mask = 4'b0001 → digit 0 anode is inactive for 2 frames (32 cycles) out of every 4; the other digits are unaffected.
- Hex mode, 16'hABCD → digits 0..3 show d, C, b, A and code_err = 0. Then switch to mode 3 → all digits blank and code_err = 1.
- Assert rst_n = 0 mid-slot on digit 2 → outputs go inactive within the same cycle. After release the first lit anode is digit 0, after the 1-cycle blank.
